// File: rtl/booth_mul_arbiter_if.sv
// Requester-side bus of the shared Booth multiplier arbiter.
// The master modport is the client side and the slave modport is the arbiter side.
interface booth_mul_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [2*WIDTH-1:0]    result;
  logic [IDW-1:0]        result_id;
  logic                  busy;

  modport master (
    output req, req_a, req_b,
    input  grant, done, result, result_id, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output grant, done, result, result_id, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency signed multiplier
// among NREQ requesters and returns each product tagged with its owner's ID.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 32
) (
  input  logic               clk,
  input  logic               rst_a,
  booth_mul_arbiter_if.slave bus,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_out
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] winner;
  logic           any_req;
  logic [IDW:0]   scan;

  // Scan from the highest offset down so the closest set request at or after
  // rr_ptr is the last one written and therefore wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    scan    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (scan >= (IDW + 1)'(NREQ))
        scan = scan - (IDW + 1)'(NREQ);
      if (bus.req[scan[IDW-1:0]]) begin
        any_req = 1'b1;
        winner  = scan[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      cnt           <= '0;
      mul_load      <= 1'b0;
      mul_a         <= '0;
      mul_b         <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.result    <= '0;
      bus.result_id <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= LOAD;
            cur_id    <= winner;
            mul_a     <= bus.req_a[int'(winner) * WIDTH +: WIDTH];
            mul_b     <= bus.req_b[int'(winner) * WIDTH +: WIDTH];
            mul_load  <= 1'b1;
            bus.grant <= NREQ'(1) << winner;
            bus.busy  <= 1'b1;
          end
        end
        LOAD: begin
          state     <= WAIT;
          mul_load  <= 1'b0;
          bus.grant <= '0;
          cnt       <= '0;
          rr_ptr    <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
        WAIT: begin
          // mul_out becomes valid exactly MUL_LAT edges after the load edge.
          if (cnt == CNT_LAST) begin
            state         <= DONE;
            cnt           <= '0;
            bus.result    <= mul_out;
            bus.result_id <= cur_id;
            bus.done      <= NREQ'(1) << cur_id;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed-vector bench for booth_mul_arbiter with a behavioural fixed-latency
// signed multiplier that shows junk until its product is due.
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 4;
  localparam int SPACING = MUL_LAT + 3;
  localparam int BUDGET  = 200;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        mul_load;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_out = '0;
  logic [63:0] pend = '0;
  int          mcnt = 0;
  int          passed = 0;
  int          total = 0;

  logic signed [63:0] ea, eb, prod;
  assign ea   = {{32{mul_a[31]}}, mul_a};
  assign eb   = {{32{mul_b[31]}}, mul_b};
  assign prod = ea * eb;

  booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst_a    (rst_a),
    .bus      (bus),
    .mul_load (mul_load),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_out  (mul_out)
  );

  always #5 clk = ~clk;

  // The product appears MUL_LAT edges after the load edge; sampling early reads junk.
  always @(posedge clk) begin
    if (mul_load) begin
      mcnt    <= MUL_LAT - 1;
      pend    <= prod;
      mul_out <= (MUL_LAT == 1) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_out <= pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done === '0 && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();
  endtask

  task automatic run_single(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp);
    int n;
    set_op(id, a, b);
    bus.req[id] = 1'b1;
    tick();
    total++;
    if (bus.grant !== 4'(1 << id) || mul_load !== 1'b1) $display("[TB] FAIL grant_load: grant=%b load=%b expected grant=%b load=1", bus.grant, mul_load, 4'(1 << id));
    else passed++;
    bus.req[id] = 1'b0;
    tick();
    total++;
    if (bus.grant !== '0) $display("[TB] FAIL grant_pulse: grant=%b expected 0000", bus.grant);
    else passed++;
    wait_done(n);
    total++;
    if (n !== MUL_LAT) $display("[TB] FAIL done_latency: got %0d cycles expected %0d", n + 2, MUL_LAT + 2);
    else passed++;
    total++;
    if (bus.done !== 4'(1 << id) || bus.result !== exp || bus.result_id !== 2'(id))
      $display("[TB] FAIL result: done=%b result=%h id=%0d expected done=%b result=%h id=%0d", bus.done, bus.result, bus.result_id, 4'(1 << id), exp, id);
    else passed++;
    tick();
    total++;
    if (bus.done !== '0 || bus.busy !== 1'b0) $display("[TB] FAIL idle_after_done: done=%b busy=%b expected 0000/0", bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    rst_a = 1'b1;
    tick();
    tick();
    total++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || mul_load !== 1'b0)
      $display("[TB] FAIL reset_ctrl: grant=%b done=%b busy=%b load=%b expected all 0", bus.grant, bus.done, bus.busy, mul_load);
    else passed++;
    total++;
    if (mul_a !== '0 || mul_b !== '0) $display("[TB] FAIL reset_ops: mul_a=%h mul_b=%h expected 0", mul_a, mul_b);
    else passed++;
    total++;
    if (bus.result !== '0 || bus.result_id !== '0) $display("[TB] FAIL reset_result: result=%h id=%0d expected 0", bus.result, bus.result_id);
    else passed++;
    rst_a = 1'b0;
    tick();
  endtask

  task automatic test_single();
    run_single(0, 32'd10, 32'd2, 64'd20);
  endtask

  task automatic test_signed();
    run_single(0, 32'hFFFF_FFF8, 32'd5, 64'hFFFF_FFFF_FFFF_FFD8);
    run_single(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
  endtask

  task automatic test_two_req();
    int n;
    do_reset();
    set_op(0, 32'd7, 32'd3);
    set_op(2, 32'd6, 32'd9);
    bus.req = 4'b0101;
    tick();
    total++;
    if (bus.grant !== 4'b0001) $display("[TB] FAIL two_first_grant: grant=%b expected 0001", bus.grant);
    else passed++;
    bus.req[0] = 1'b0;
    wait_done(n);
    total++;
    if (bus.done !== 4'b0001 || bus.result !== 64'd21 || bus.result_id !== 2'd0)
      $display("[TB] FAIL two_first_result: done=%b result=%0d id=%0d expected 0001/21/0", bus.done, bus.result, bus.result_id);
    else passed++;
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) $display("[TB] FAIL two_bubble: busy=%b grant=%b expected 0/0000", bus.busy, bus.grant);
    else passed++;
    tick();
    total++;
    if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) $display("[TB] FAIL two_second_grant: grant=%b busy=%b expected 0100/1", bus.grant, bus.busy);
    else passed++;
    bus.req[2] = 1'b0;
    wait_done(n);
    total++;
    if (bus.done !== 4'b0100 || bus.result !== 64'd54 || bus.result_id !== 2'd2)
      $display("[TB] FAIL two_second_result: done=%b result=%0d id=%0d expected 0100/54/2", bus.done, bus.result, bus.result_id);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [63:0] exp_prod [4] = '{64'd6, 64'd12, 64'd20, 64'd30};
    int ng = 0;
    int nd = 0;
    int c = 0;
    int last = 0;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2), 32'(i + 3));
    bus.req = 4'b1111;
    while ((ng < 6 || nd < 6) && c < 6 * SPACING + 40) begin
      tick();
      c++;
      if (bus.grant !== '0) begin
        total++;
        if (ng >= 6) $display("[TB] FAIL rr_extra_grant: grant=%b expected no grant", bus.grant);
        else if (bus.grant !== 4'(1 << exp_order[ng])) $display("[TB] FAIL rr_order%0d: grant=%b expected %b", ng, bus.grant, 4'(1 << exp_order[ng]));
        else passed++;
        if (ng > 0) begin
          total++;
          if (c - last !== SPACING) $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d", ng, c - last, SPACING);
          else passed++;
        end
        last = c;
        ng++;
        if (ng == 6) bus.req = '0;
      end
      if (bus.done !== '0 && nd < 6) begin
        total++;
        if (bus.done !== 4'(1 << exp_order[nd]) || bus.result !== exp_prod[exp_order[nd]])
          $display("[TB] FAIL rr_result%0d: done=%b result=%0d expected %b/%0d", nd, bus.done, bus.result, 4'(1 << exp_order[nd]), exp_prod[exp_order[nd]]);
        else passed++;
        nd++;
      end
    end
    bus.req = '0;
    total++;
    if (ng !== 6 || nd !== 6) $display("[TB] FAIL rr_count: grants=%0d dones=%0d expected 6/6", ng, nd);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_op(1, 32'd3, 32'd3);
    set_op(2, 32'd5, 32'd5);
    set_op(3, 32'd4, 32'd4);
    bus.req = 4'b0100;
    tick();
    total++;
    if (bus.grant !== 4'b0100) $display("[TB] FAIL mid_setup_grant: grant=%b expected 0100", bus.grant);
    else passed++;
    bus.req = 4'b1010;
    tick();
    tick();
    #2;
    rst_a = 1'b1;
    #1;
    total++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || mul_load !== 1'b0 ||
        mul_a !== '0 || mul_b !== '0 || bus.result !== '0 || bus.result_id !== '0)
      $display("[TB] FAIL mid_reset_outputs: grant=%b done=%b busy=%b load=%b a=%h b=%h result=%h id=%0d expected all 0",
               bus.grant, bus.done, bus.busy, mul_load, mul_a, mul_b, bus.result, bus.result_id);
    else passed++;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    tick();
    total++;
    if (bus.grant !== 4'b0010 || bus.done !== '0) $display("[TB] FAIL mid_regrant: grant=%b done=%b expected 0010/0000", bus.grant, bus.done);
    else passed++;
    bus.req = '0;
    wait_done(n);
    total++;
    if (n !== MUL_LAT + 1 || bus.done !== 4'b0010 || bus.result !== 64'd9)
      $display("[TB] FAIL mid_result: cycles=%0d done=%b result=%0d expected %0d/0010/9", n, bus.done, bus.result, MUL_LAT + 1);
    else passed++;
    tick();
  endtask

  task automatic test_operand_change();
    int n;
    set_op(1, 32'd15, 32'd9);
    bus.req[1] = 1'b1;
    tick();
    total++;
    if (bus.grant !== 4'b0010) $display("[TB] FAIL chg_grant: grant=%b expected 0010", bus.grant);
    else passed++;
    set_op(1, 32'd11, 32'd4);
    bus.req[1] = 1'b0;
    wait_done(n);
    total++;
    if (bus.done !== 4'b0010 || bus.result !== 64'd135 || bus.result_id !== 2'd1)
      $display("[TB] FAIL chg_result: done=%b result=%0d id=%0d expected 0010/135/1", bus.done, bus.result, bus.result_id);
    else passed++;
    total++;
    if (mul_a !== 32'd15 || mul_b !== 32'd9) $display("[TB] FAIL chg_ops_stable: mul_a=%0d mul_b=%0d expected 15/9", mul_a, mul_b);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_two_req();
    test_back_to_back();
    test_reset_mid();
    test_operand_change();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
